// File: rtl/leds_pattern_show.sv
// Button-driven LED pattern player: a synchronized, debounced push button
// steps through OFF, ALL_ON, BLINK and CHASE, paced by a free-running step timer.
module leds_pattern_show #(
    parameter int N_LEDS          = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STEP_CYCLES     = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pushButton,
    output logic [N_LEDS-1:0] leds,
    output logic [1:0]        mode
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int STW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DBW-1:0]    DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [STW-1:0]    ST_LAST  = STW'(STEP_CYCLES - 1);
    localparam logic [N_LEDS-1:0] PTR_INIT = N_LEDS'(1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ALL_ON = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    logic              r_s1;
    logic              r_s2;
    logic              r_stable;
    logic              r_stable_d;
    logic [DBW-1:0]    r_db_cnt;
    logic [STW-1:0]    r_timer;
    logic              r_phase;
    logic [N_LEDS-1:0] r_ptr;
    mode_t             r_mode;
    mode_t             w_mode_next;
    logic              w_press;
    logic              w_tick;

    // Synchronizer and debouncer: a level is accepted only after it differs
    // from the stable value for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_s1       <= pushButton;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
            if (r_s2 != r_stable) begin
                if (r_db_cnt == DB_LAST) begin
                    r_stable <= r_s2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + DBW'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_press = r_stable & ~r_stable_d;
    assign w_tick  = (r_timer == ST_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode <= MODE_OFF;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (w_press) begin
            case (r_mode)
                MODE_OFF:    w_mode_next = MODE_ALL_ON;
                MODE_ALL_ON: w_mode_next = MODE_BLINK;
                MODE_BLINK:  w_mode_next = MODE_CHASE;
                MODE_CHASE:  w_mode_next = MODE_OFF;
                default:     w_mode_next = MODE_OFF;
            endcase
        end
    end

    // A press restarts the pattern from its first step, discarding any tick on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
            r_phase <= 1'b1;
            r_ptr   <= PTR_INIT;
        end else if (w_press) begin
            r_timer <= '0;
            r_phase <= 1'b1;
            r_ptr   <= PTR_INIT;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + STW'(1);
            if (w_tick && r_mode == MODE_BLINK) begin
                r_phase <= ~r_phase;
            end
            if (w_tick && r_mode == MODE_CHASE) begin
                r_ptr <= {r_ptr[N_LEDS-2:0], r_ptr[N_LEDS-1]};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_LEDS; gi++) begin : g_led
            assign leds[gi] = (r_mode == MODE_ALL_ON)
                            | ((r_mode == MODE_BLINK) & r_phase)
                            | ((r_mode == MODE_CHASE) & r_ptr[gi]);
        end
    endgenerate

    assign mode = r_mode;

endmodule
